// File: rtl/wallace_pkg.sv
// Shared helpers for the pipelined Wallace multiplier.
// Row helpers work at the widest legal operand; callers trim to PROD_W.
package wallace_pkg;

  localparam int N_STAGES = 3;
  localparam int MAX_W = 32;
  localparam int MAX_PW = 2 * MAX_W;

  // Baugh-Wooley row: MSB row/column cross terms inverted,
  // the two correction ones ride in the free bits of row 0.
  function automatic logic [MAX_PW-1:0] pp_row(
    input logic [MAX_W-1:0] a,
    input logic             b_bit,
    input int               row,
    input logic             signed_mode,
    input int               width
  );
    logic [MAX_PW-1:0] r;
    logic t;
    r = '0;
    for (int j = 0; j < MAX_W; j++) begin
      if (j < width) begin
        t = (|(a & (MAX_W'(1) << j))) & b_bit;
        if (signed_mode && ((j == width - 1) != (row == width - 1)))
          t = ~t;
        r = r | (MAX_PW'(t) << (row + j));
      end
    end
    if (signed_mode && row == 0) begin
      r = r | (MAX_PW'(1) << width);
      r = r | (MAX_PW'(1) << (2 * width - 1));
    end
    return r;
  endfunction

  function automatic int next_rows(input int n);
    return (n / 3) * 2 + n % 3;
  endfunction

  function automatic int rows_at(input int n, input int lvl);
    int r;
    r = n;
    for (int i = 0; i < lvl; i++)
      if (r > 2) r = next_rows(r);
    return r;
  endfunction

  function automatic int n_levels(input int n);
    int r;
    int l;
    r = n;
    l = 0;
    while (r > 2) begin
      r = next_rows(r);
      l++;
    end
    return l;
  endfunction

endpackage

// File: rtl/FullAdder.sv
// 3:2 counter cell.
module FullAdder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

// File: rtl/HalfAdder.sv
// 2:2 counter cell.
module HalfAdder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic co
);
  assign s  = x ^ y;
  assign co = x & y;
endmodule

// File: rtl/wallace_csa_tree.sv
// Combinational Wallace reduction: WIDTH rows down to sum/carry.
// Each level groups rows in threes; carries out of the top bit wrap away.
module wallace_csa_tree
  import wallace_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2*WIDTH-1:0] pp [WIDTH],
  output logic [2*WIDTH-1:0] sum,
  output logic [2*WIDTH-1:0] carry
);
  localparam int PROD_W = 2 * WIDTH;
  localparam int NLEV = n_levels(WIDTH);

  for (genvar l = 0; l <= NLEV; l++) begin : lv
    localparam int RN = rows_at(WIDTH, l);
    logic [PROD_W-1:0] r [RN];

    if (l == 0) begin : g_in
      for (genvar k = 0; k < WIDTH; k++) begin : g_row
        assign r[k] = pp[k];
      end
    end else begin : g_red
      localparam int PN = rows_at(WIDTH, l - 1);
      localparam int NG = PN / 3;
      localparam int RM = PN % 3;

      for (genvar g = 0; g < NG; g++) begin : grp
        logic [PROD_W-1:0] s;
        logic [PROD_W-1:0] c;
        for (genvar b = 0; b < PROD_W - 1; b++) begin : g_fa
          FullAdder fa (
            .x  (lv[l-1].r[3*g][b]),
            .y  (lv[l-1].r[3*g+1][b]),
            .ci (lv[l-1].r[3*g+2][b]),
            .s  (s[b]),
            .co (c[b+1])
          );
        end
        assign s[PROD_W-1] = lv[l-1].r[3*g][PROD_W-1]
                           ^ lv[l-1].r[3*g+1][PROD_W-1]
                           ^ lv[l-1].r[3*g+2][PROD_W-1];
        assign c[0] = 1'b0;
        assign r[2*g] = s;
        assign r[2*g+1] = c;
      end

      if (RM == 1) begin : g_one
        assign r[2*NG] = lv[l-1].r[3*NG];
      end else if (RM == 2) begin : g_two
        logic [PROD_W-1:0] s;
        logic [PROD_W-1:0] c;
        for (genvar b = 0; b < PROD_W - 1; b++) begin : g_ha
          HalfAdder ha (
            .x  (lv[l-1].r[3*NG][b]),
            .y  (lv[l-1].r[3*NG+1][b]),
            .s  (s[b]),
            .co (c[b+1])
          );
        end
        assign s[PROD_W-1] = lv[l-1].r[3*NG][PROD_W-1]
                           ^ lv[l-1].r[3*NG+1][PROD_W-1];
        assign c[0] = 1'b0;
        assign r[2*NG] = s;
        assign r[2*NG+1] = c;
      end
    end
  end

  assign sum = lv[NLEV].r[0];
  assign carry = lv[NLEV].r[1];

endmodule

// File: rtl/wallace_multiplier_pipe.sv
// Three-stage pipelined Baugh-Wooley/Wallace multiplier
// with valid/ready on both sides and per-stage enables.
module wallace_multiplier_pipe
  import wallace_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod,
  output logic [TAG_W-1:0]   out_tag
);
  localparam int PROD_W = 2 * WIDTH;

  logic [PROD_W-1:0] pp [WIDTH];
  logic [PROD_W-1:0] s1_pp [WIDTH];
  logic [PROD_W-1:0] t_sum, t_cy;
  logic [PROD_W-1:0] s2_sum, s2_cy, s3_prod;
  logic [TAG_W-1:0]  s1_tag, s2_tag, s3_tag;
  logic              s1_v, s2_v, s3_v;
  logic              en1, en2, en3;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pp
    assign pp[i] = PROD_W'(pp_row(MAX_W'(a), b[i], i,
                                  signed_mode, WIDTH));
  end

  // A stage may load when it is empty or its contents move on.
  assign en3 = !s3_v || out_ready;
  assign en2 = !s2_v || en3;
  assign en1 = !s1_v || en2;
  assign in_ready = en1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v <= 1'b0;
      s1_tag <= '0;
      for (int i = 0; i < WIDTH; i++) s1_pp[i] <= '0;
    end else if (en1) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_pp <= pp;
        s1_tag <= in_tag;
      end
    end
  end

  wallace_csa_tree #(.WIDTH(WIDTH)) u_tree (
    .pp    (s1_pp),
    .sum   (t_sum),
    .carry (t_cy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v <= 1'b0;
      s2_sum <= '0;
      s2_cy <= '0;
      s2_tag <= '0;
    end else if (en2) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_sum <= t_sum;
        s2_cy <= t_cy;
        s2_tag <= s1_tag;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_v <= 1'b0;
      s3_prod <= '0;
      s3_tag <= '0;
    end else if (en3) begin
      s3_v <= s2_v;
      if (s2_v) begin
        s3_prod <= s2_sum + s2_cy;
        s3_tag <= s2_tag;
      end
    end
  end

  assign out_valid = s3_v;
  assign prod = s3_prod;
  assign out_tag = s3_tag;

endmodule

// File: tb/tb_wallace_multiplier_pipe.sv
// Directed table, streaming, stall and reset checks at WIDTH=8,
// plus WIDTH 4/16/32 sweeps against a two's-complement model.
`timescale 1ns/1ps
module tb_wallace_multiplier_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;
  bit sweep_go = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input bit sm, input int w);
    logic [63:0] ex, ey, p;
    ex = {32'd0, x};
    ey = {32'd0, y};
    if (sm && x[w-1]) ex = ex | (~64'd0 << w);
    if (sm && y[w-1]) ey = ey | (~64'd0 << w);
    p = ex * ey;
    if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
    return p;
  endfunction

  logic        iv, ir, sm, ov, ordy;
  logic [7:0]  a, b;
  logic [3:0]  it, ot;
  logic [15:0] p;

  wallace_multiplier_pipe #(.WIDTH(8), .TAG_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (iv),
    .in_ready    (ir),
    .a           (a),
    .b           (b),
    .signed_mode (sm),
    .in_tag      (it),
    .out_valid   (ov),
    .out_ready   (ordy),
    .prod        (p),
    .out_tag     (ot)
  );

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sm;
    logic [3:0]  tag;
    logic [15:0] exp;
  } vec_t;

  vec_t vt [12];

  task automatic run_vec(input vec_t v, input string nm);
    int lat;
    @(negedge clk);
    a = v.a; b = v.b; sm = v.sm; it = v.tag;
    iv = 1'b1; ordy = 1'b1;
    #1;
    chk({nm, "_in_ready"}, 64'(ir), 64'd1);
    @(negedge clk);
    iv = 1'b0; a = ~v.a; b = ~v.b; sm = ~v.sm; it = ~v.tag;
    #1;
    lat = 1;
    while (!ov && lat < 10) begin
      @(negedge clk);
      #1;
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'd3);
    chk({nm, "_prod"}, 64'(p), 64'(v.exp));
    chk({nm, "_tag"}, 64'(ot), 64'(v.tag));
  endtask

  task automatic stream(input int nops, input int stall_at,
                        input string nm);
    logic [15:0] qe[$];
    logic [3:0]  qt[$];
    int          qc[$];
    int k, got, cyc;
    bit have, held;
    logic [15:0] hp;
    logic [3:0]  ht;
    k = 0; got = 0; cyc = 0;
    have = 1'b0; held = 1'b0; hp = '0; ht = '0;
    while ((k < nops || qe.size() > 0) && cyc < 400) begin
      @(negedge clk);
      ordy = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5);
      if (!have && k < nops) begin
        a = 8'($urandom); b = 8'($urandom);
        sm = 1'($urandom); it = 4'(k);
        have = 1'b1;
      end
      iv = have;
      #1;
      if (!ordy) begin
        chk({nm, "_stall_in_ready"}, 64'(ir), 64'd0);
        chk({nm, "_stall_valid"}, 64'(ov), 64'd1);
        if (!held) begin
          hp = p; ht = ot; held = 1'b1;
        end else begin
          chk({nm, "_hold_prod"}, 64'(p), 64'(hp));
          chk({nm, "_hold_tag"}, 64'(ot), 64'(ht));
        end
      end else begin
        chk({nm, "_in_ready"}, 64'(ir), 64'd1);
      end
      if (ov && ordy) begin
        chk({nm, "_expected_output"}, 64'(qe.size() > 0), 64'd1);
        if (qe.size() > 0) begin
          chk({nm, "_prod"}, 64'(p), 64'(qe.pop_front()));
          chk({nm, "_tag"}, 64'(ot), 64'(qt.pop_front()));
          if (stall_at < 0)
            chk({nm, "_latency"}, 64'(cyc - qc.pop_front()), 64'd3);
          else
            void'(qc.pop_front());
        end
        got++;
      end
      if (iv && ir) begin
        qe.push_back(16'(ref_mul(32'(a), 32'(b), sm, 8)));
        qt.push_back(it);
        qc.push_back(cyc);
        k++;
        have = 1'b0;
      end
      cyc++;
    end
    iv = 1'b0; ordy = 1'b1;
    chk({nm, "_accepted"}, 64'(k), 64'(nops));
    chk({nm, "_emitted"}, 64'(got), 64'(nops));
  endtask

  initial begin
    rst = 1'b0; iv = 1'b0; ordy = 1'b1;
    a = '0; b = '0; sm = 1'b0; it = '0;
    vt[0]  = '{8'hFF, 8'hFF, 1'b0, 4'd3,  16'hFE01};
    vt[1]  = '{8'h80, 8'h80, 1'b1, 4'd1,  16'h4000};
    vt[2]  = '{8'hFF, 8'h01, 1'b1, 4'd2,  16'hFFFF};
    vt[3]  = '{8'hFF, 8'h01, 1'b0, 4'd4,  16'h00FF};
    vt[4]  = '{8'h07, 8'h09, 1'b0, 4'd5,  16'h003F};
    vt[5]  = '{8'h80, 8'h7F, 1'b1, 4'd6,  16'hC080};
    vt[6]  = '{8'h7F, 8'h7F, 1'b1, 4'd7,  16'h3F01};
    vt[7]  = '{8'h80, 8'hFF, 1'b1, 4'd8,  16'h0080};
    vt[8]  = '{8'h00, 8'hA5, 1'b1, 4'd9,  16'h0000};
    vt[9]  = '{8'hFF, 8'hFF, 1'b1, 4'd10, 16'h0001};
    vt[10] = '{8'hC3, 8'h5A, 1'b0, 4'd11, 16'h448E};
    vt[11] = '{8'hC3, 8'h5A, 1'b1, 4'd12, 16'hEA8E};

    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", 64'(ov), 64'd0);
    chk("rst_prod", 64'(p), 64'd0);
    chk("rst_out_tag", 64'(ot), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(ir), 64'd1);
    chk("post_rst_out_valid", 64'(ov), 64'd0);

    for (int i = 0; i < 12; i++)
      run_vec(vt[i], $sformatf("vec%0d", i));

    stream(16, -1, "b2b");
    stream(20, 6, "stall");

    @(negedge clk);
    ordy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 8'(i + 3); b = 8'(i + 5); sm = 1'b0; it = 4'(i);
      iv = 1'b1;
      @(negedge clk);
    end
    iv = 1'b0;
    #1;
    chk("inflight_out_valid", 64'(ov), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(ov), 64'd0);
    chk("midrst_prod", 64'(p), 64'd0);
    chk("midrst_out_tag", 64'(ot), 64'd0);
    chk("midrst_in_ready", 64'(ir), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_vec('{8'd7, 8'd9, 1'b0, 4'd5, 16'd63}, "after_rst");

    sweep_go = 1'b1;
    wait (n_done == 3);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  for (genvar g = 0; g < 3; g++) begin : gw
    localparam int W = (g == 0) ? 4 : (g == 1) ? 16 : 32;
    localparam int NOPS = (g == 0) ? 512 : 300;

    logic           siv, sir, ssm, sov, sordy;
    logic [W-1:0]   sa, sb;
    logic [3:0]     sit, sot;
    logic [2*W-1:0] sp;

    wallace_multiplier_pipe #(.WIDTH(W), .TAG_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (siv),
      .in_ready    (sir),
      .a           (sa),
      .b           (sb),
      .signed_mode (ssm),
      .in_tag      (sit),
      .out_valid   (sov),
      .out_ready   (sordy),
      .prod        (sp),
      .out_tag     (sot)
    );

    initial begin
      logic [63:0] qe[$];
      logic [3:0]  qt[$];
      int k, got, cyc;
      bit have;
      siv = 1'b0; sordy = 1'b1; ssm = 1'b0;
      sa = '0; sb = '0; sit = '0;
      k = 0; got = 0; cyc = 0; have = 1'b0;
      wait (sweep_go);
      while ((k < NOPS || qe.size() > 0) && cyc < 20000) begin
        @(negedge clk);
        sordy = ($urandom_range(0, 3) != 0);
        if (!have && k < NOPS && $urandom_range(0, 4) != 0) begin
          if (W == 4) begin
            sa = W'(k); sb = W'(k >> 4); ssm = k[8];
          end else begin
            sa = W'($urandom); sb = W'($urandom);
            ssm = 1'($urandom);
          end
          sit = 4'(k);
          have = 1'b1;
        end
        siv = have;
        #1;
        if (sov && sordy) begin
          chk($sformatf("w%0d_expected_output", W),
              64'(qe.size() > 0), 64'd1);
          if (qe.size() > 0) begin
            chk($sformatf("w%0d_prod", W), 64'(sp), qe.pop_front());
            chk($sformatf("w%0d_tag", W), 64'(sot),
                64'(qt.pop_front()));
          end
          got++;
        end
        if (siv && sir) begin
          qe.push_back(ref_mul(32'(sa), 32'(sb), ssm, W));
          qt.push_back(sit);
          k++;
          have = 1'b0;
        end
        cyc++;
      end
      siv = 1'b0; sordy = 1'b1;
      chk($sformatf("w%0d_emitted", W), 64'(got), 64'(NOPS));
      n_done++;
    end
  end

endmodule
